dmx_tx: RTL and testbench



---
 rtl/dmx_pkg.sv | 17 +
 rtl/dmx_bit_timer.sv | 30 +++
 rtl/dmx_tx.sv | 166 ++++++++++++++++
 tb/tb_dmx_tx.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/dmx_pkg.sv
// Shared DMX512 constants and the transmitter state encoding.
package dmx_pkg;

    localparam int         DMX_BAUD       = 250000;
    localparam logic [7:0] DMX_START_CODE = 8'h00;
    localparam int         DMX_SLOT_BITS  = 11;
    localparam int         DMX_BREAK_BITS = 22;
    localparam int         DMX_MAB_BITS   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BREAK = 2'd1,
        MAB   = 2'd2,
        SLOT  = 2'd3
    } dmx_state_t;

endpackage

// File: rtl/dmx_bit_timer.sv
// Bit-period timer: free-running 0..BIT_CLKS-1 counter with an end-of-bit tick,
// held at zero while sync is high so each state starts on a fresh bit boundary.
module dmx_bit_timer #(
    parameter int BIT_CLKS = 48
) (
    input  logic CLK12,
    input  logic RST,
    input  logic sync,
    output logic bit_tick
);

    localparam int CW = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(BIT_CLKS - 1);

    logic [CW-1:0] cnt_r;

    // Count cycles within the current bit period, restarting on sync or wrap.
    always_ff @(posedge CLK12 or posedge RST) begin
        if (RST) begin
            cnt_r <= '0;
        end else if (sync || (cnt_r == LAST)) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + 1'b1;
        end
    end

    assign bit_tick = !sync && (cnt_r == LAST);

endmodule

// File: rtl/dmx_tx.sv
// DMX512 universe transmitter: break, mark-after-break, start code and
// CHANNELS data slots read from a 1-cycle-latency channel RAM.
module dmx_tx
    import dmx_pkg::*;
#(
    parameter int CLK_HZ     = 12000000,
    parameter int BAUD       = DMX_BAUD,
    parameter int CHANNELS   = 512,
    parameter int BREAK_BITS = DMX_BREAK_BITS,
    parameter int MAB_BITS   = DMX_MAB_BITS
) (
    input  logic       CLK12,
    input  logic       RST,
    input  logic       en,
    output logic       rd_en,
    output logic [8:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       tx,
    output logic       gate,
    output logic       busy,
    output logic       frame_done
);

    localparam int BIT_CLKS = CLK_HZ / BAUD;

    localparam logic [7:0] BREAK_LAST = 8'(BREAK_BITS - 1);
    localparam logic [7:0] MAB_LAST   = 8'(MAB_BITS - 1);
    localparam logic [7:0] SLOT_LAST  = 8'(DMX_SLOT_BITS - 1);
    localparam logic [9:0] LAST_SLOT  = 10'(CHANNELS);

    dmx_state_t  state_r;
    logic        en_r;
    logic [7:0]  bit_cnt_r;
    logic [9:0]  slot_cnt_r;
    logic [7:0]  shift_r;
    logic        fetch_r;
    logic        bit_tick_s;
    logic        sync_s;

    // Keep the bit timer parked until a frame starts.
    assign sync_s = (state_r == IDLE);

    dmx_bit_timer #(
        .BIT_CLKS (BIT_CLKS)
    ) u_bit_timer (
        .CLK12    (CLK12),
        .RST      (RST),
        .sync     (sync_s),
        .bit_tick (bit_tick_s)
    );

    // Frame sequencer: state, bit/slot counters, shifter, RAM fetch and all pin outputs.
    always_ff @(posedge CLK12 or posedge RST) begin
        if (RST) begin
            state_r    <= IDLE;
            en_r       <= 1'b0;
            bit_cnt_r  <= 8'd0;
            slot_cnt_r <= 10'd0;
            shift_r    <= 8'd0;
            fetch_r    <= 1'b0;
            rd_en      <= 1'b0;
            rd_addr    <= 9'd0;
            tx         <= 1'b1;
            gate       <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            en_r       <= en;
            rd_en      <= 1'b0;
            frame_done <= 1'b0;
            // RAM answers one cycle after the strobe; capture it then.
            fetch_r    <= rd_en;
            if (fetch_r) begin
                shift_r <= rd_data;
            end

            case (state_r)
                IDLE: begin
                    bit_cnt_r  <= 8'd0;
                    slot_cnt_r <= 10'd0;
                    if (en_r) begin
                        state_r <= BREAK;
                        tx      <= 1'b0;
                        gate    <= 1'b1;
                        busy    <= 1'b1;
                    end else begin
                        tx      <= 1'b1;
                        gate    <= 1'b0;
                        busy    <= 1'b0;
                    end
                end

                BREAK: begin
                    if (bit_tick_s) begin
                        if (bit_cnt_r == BREAK_LAST) begin
                            state_r   <= MAB;
                            tx        <= 1'b1;
                            bit_cnt_r <= 8'd0;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 8'd1;
                        end
                    end
                end

                MAB: begin
                    if (bit_tick_s) begin
                        if (bit_cnt_r == MAB_LAST) begin
                            state_r    <= SLOT;
                            tx         <= 1'b0;
                            bit_cnt_r  <= 8'd0;
                            slot_cnt_r <= 10'd0;
                            shift_r    <= DMX_START_CODE;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 8'd1;
                        end
                    end
                end

                SLOT: begin
                    if (bit_tick_s) begin
                        if (bit_cnt_r == SLOT_LAST) begin
                            bit_cnt_r <= 8'd0;
                            if (slot_cnt_r == LAST_SLOT) begin
                                frame_done <= 1'b1;
                                slot_cnt_r <= 10'd0;
                                if (en_r) begin
                                    state_r <= BREAK;
                                    tx      <= 1'b0;
                                end else begin
                                    state_r <= IDLE;
                                    tx      <= 1'b1;
                                    gate    <= 1'b0;
                                    busy    <= 1'b0;
                                end
                            end else begin
                                slot_cnt_r <= slot_cnt_r + 10'd1;
                                tx         <= 1'b0;
                            end
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 8'd1;
                            if (bit_cnt_r < 8'd8) begin
                                tx      <= shift_r[0];
                                shift_r <= {1'b0, shift_r[7:1]};
                            end else begin
                                tx      <= 1'b1;
                            end
                            // Second stop bit begins: prefetch the next slot's byte.
                            if ((bit_cnt_r == 8'd9) && (slot_cnt_r < LAST_SLOT)) begin
                                rd_en   <= 1'b1;
                                rd_addr <= slot_cnt_r[8:0];
                            end
                        end
                    end
                end

                default: begin
                    state_r <= IDLE;
                    tx      <= 1'b1;
                    gate    <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmx_tx.sv
// Directed bench for dmx_tx with a 4-channel universe and a 1-cycle RAM model.
module tb_dmx_tx;

    localparam int CH = 4;

    logic       CLK12 = 1'b0;
    logic       RST;
    logic       en;
    logic       rd_en;
    logic [8:0] rd_addr;
    logic [7:0] rd_data;
    logic       tx;
    logic       gate;
    logic       busy;
    logic       frame_done;

    logic [7:0] mem [0:3];
    logic [8:0] rd_log [0:7];
    int         rd_cnt = 0;
    int         fd_cnt = 0;
    int         fd_cyc = 0;
    int         cyc    = 0;
    int         vecs   = 0;
    int         miss   = 0;

    always #5 CLK12 = ~CLK12;

    dmx_tx #(.CHANNELS(CH)) dut (
        .CLK12      (CLK12),
        .RST        (RST),
        .en         (en),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .tx         (tx),
        .gate       (gate),
        .busy       (busy),
        .frame_done (frame_done)
    );

    // Channel RAM with one cycle of read latency.
    always @(posedge CLK12) begin
        if (rd_en) rd_data <= mem[rd_addr[1:0]];
    end

    // Cycle counter plus logs of RAM reads and frame_done pulses.
    always @(posedge CLK12) begin
        cyc <= cyc + 1;
        if (rd_en) begin
            if (rd_cnt < 8) rd_log[rd_cnt] <= rd_addr;
            rd_cnt <= rd_cnt + 1;
        end
        if (frame_done) begin
            fd_cnt <= fd_cnt + 1;
            fd_cyc <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sample one bit period starting at the current negedge; ends on the next bit.
    task automatic grab_bit(output logic v, output logic st);
        v  = tx;
        st = 1'b1;
        for (int i = 1; i < 48; i++) begin
            @(negedge CLK12);
            if (tx !== v) st = 1'b0;
        end
        @(negedge CLK12);
    endtask

    initial begin
        int         n;
        int         t_en;
        int         t_fall;
        int         t0;
        int         t1;
        int         bad;
        int         fd0;
        logic [7:0] exp_byte;
        logic [7:0] got;
        logic [2:0] frm;
        logic       stable;
        logic       v;
        logic       st;

        mem[0] = 8'hA5; mem[1] = 8'h01; mem[2] = 8'h80; mem[3] = 8'hFF;
        RST = 1'b1;
        en  = 1'b0;
        repeat (3) @(negedge CLK12);
        check("rst_tx",   tx,         32'd1);
        check("rst_gate", gate,       32'd0);
        check("rst_busy", busy,       32'd0);
        check("rst_rden", rd_en,      32'd0);
        check("rst_addr", rd_addr,    32'd0);
        check("rst_fd",   frame_done, 32'd0);
        RST = 1'b0;
        @(negedge CLK12);

        // Single frame, en pulsed and dropped during MAB.
        fd0  = fd_cnt;
        en   = 1'b1;
        t_en = cyc;
        @(negedge CLK12);
        check("lat1_tx", tx, 32'd1);
        @(negedge CLK12);
        check("lat2_tx", tx, 32'd0);
        check("brk_gate", gate, 32'd1);
        check("brk_busy", busy, 32'd1);
        t_fall = cyc;
        n = 0;
        while (tx === 1'b0 && n < 2000) begin n++; @(negedge CLK12); end
        check("break_len", n, 32'd1056);
        en = 1'b0;
        n = 0;
        while (tx === 1'b1 && n < 500) begin n++; @(negedge CLK12); end
        check("mab_len", n, 32'd144);
        for (int s = 0; s <= CH; s++) begin
            stable = 1'b1;
            got    = 8'h00;
            frm    = 3'b000;
            for (int b = 0; b < 11; b++) begin
                grab_bit(v, st);
                stable = stable & st;
                if (b == 0) frm[0] = v;
                else if (b <= 8) got[b-1] = v;
                else frm[b-8] = v;
            end
            exp_byte = (s == 0) ? 8'h00 : mem[s-1];
            check($sformatf("slot%0d_data", s),   got,    exp_byte);
            check($sformatf("slot%0d_frame", s),  frm,    32'b110);
            check($sformatf("slot%0d_stable", s), stable, 32'd1);
        end
        check("end_fd",   frame_done, 32'd1);
        check("end_tx",   tx,         32'd1);
        check("end_gate", gate,       32'd0);
        check("end_busy", busy,       32'd0);
        check("end_time", cyc - t_fall, 32'd3840);
        @(negedge CLK12);
        check("fd_width", frame_done, 32'd0);
        check("fd_count", fd_cnt - fd0, 32'd1);
        check("fd_cycle", fd_cyc - t_en, 32'd3842);
        check("rd_count", rd_cnt, 32'd4);
        for (int i = 0; i < 4; i++) check($sformatf("rd_addr%0d", i), rd_log[i], i);
        repeat (20) @(negedge CLK12);
        check("idle_tx",   tx,   32'd1);
        check("idle_gate", gate, 32'd0);
        check("idle_busy", busy, 32'd0);

        // Back-to-back frames, then en dropped mid-slot 2 of the second one.
        en = 1'b1;
        n = 0;
        while (tx !== 1'b0 && n < 10) begin n++; @(negedge CLK12); end
        t0  = cyc;
        bad = 0;
        n   = 0;
        while (frame_done !== 1'b1 && n < 10000) begin
            if (gate !== 1'b1) bad++;
            n++;
            @(negedge CLK12);
        end
        check("b2b_period1", cyc - t0, 32'd3840);
        check("b2b_tx",   tx,   32'd0);
        check("b2b_gate", gate, 32'd1);
        check("b2b_busy", busy, 32'd1);
        t1 = cyc;
        for (int i = 0; i < 2584; i++) begin
            @(negedge CLK12);
            if (gate !== 1'b1) bad++;
        end
        en = 1'b0;
        n  = 0;
        while (frame_done !== 1'b1 && n < 10000) begin
            if (gate !== 1'b1) bad++;
            n++;
            @(negedge CLK12);
        end
        check("b2b_period2", cyc - t1, 32'd3840);
        check("b2b_gate_held", bad, 32'd0);
        check("drop_tx",   tx,   32'd1);
        check("drop_gate", gate, 32'd0);
        check("drop_busy", busy, 32'd0);
        repeat (5) @(negedge CLK12);
        check("drop_idle_tx", tx, 32'd1);

        // Asynchronous reset while a RAM read strobe is active.
        en = 1'b1;
        n  = 0;
        while (rd_en !== 1'b1 && n < 5000) begin n++; @(negedge CLK12); end
        check("pre_rst_rden", rd_en, 32'd1);
        RST = 1'b1;
        en  = 1'b0;
        #1;
        check("arst_tx",   tx,    32'd1);
        check("arst_gate", gate,  32'd0);
        check("arst_busy", busy,  32'd0);
        check("arst_rden", rd_en, 32'd0);
        @(negedge CLK12);
        RST = 1'b0;
        bad = 0;
        repeat (1000) begin
            @(negedge CLK12);
            if (tx !== 1'b1 || gate !== 1'b0 || busy !== 1'b0 || rd_en !== 1'b0) bad++;
        end
        check("post_rst_idle", bad, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
